// File: rtl/scalar_mul_ctrl.sv
// Sequencer issuing the ALU job stream for one Edwards-curve scalar multiplication.
// Latency: first alu_valid one cycle after start; each job or chain element advances the cycle after alu_ready.
// Backpressure: waits on alu_ready for every element; a watchdog aborts with err if the ALU stalls past TIMEOUT.
//
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   start, scalar         : request and multiplier k (sampled in IDLE only)
//   alu_ready             : ALU end-of-element pulse
//   alu_valid, alu_state  : job start pulse and job code (0 PRE, 1 DOUBLE, 2 DIV-INV, 3 DIV-MUL)
//   alu_keep_flag         : chain continues after the current element
//   alu_consecutive_flag  : DOUBLE appends ADD / DIV-INV multiplies by Z
//   busy, done, err       : status; err qualifies done
//   phase                 : current FSM state for debug
module scalar_mul_ctrl #(
  parameter logic [254:0] EXP     = {{250{1'b1}}, 5'b01011},
  parameter int unsigned  TIMEOUT = 31
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [254:0] scalar,
  input  logic         alu_ready,
  output logic         alu_valid,
  output logic [1:0]   alu_state,
  output logic         alu_keep_flag,
  output logic         alu_consecutive_flag,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [2:0]   phase
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_DBL  = 3'd2,
    S_INV  = 3'd3,
    S_MUL  = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t         state;
  logic [254:0]   k;
  logic [7:0]     m;
  logic [7:0]     i;
  logic [7:0]     j;
  logic [4:0]     wd;
  logic [7:0]     msb;
  logic           active;
  logic [4:0]     wd_inc;
  logic           wd_expire;

  // Priority encode of the highest set bit of the incoming scalar.
  always_comb begin
    msb = 8'd0;
    for (int b = 0; b < 255; b++) begin
      if (scalar[b]) msb = 8'(b);
    end
  end

  assign active = (state == S_PRE) || (state == S_DBL) ||
                  (state == S_INV) || (state == S_MUL);
  assign wd_inc = wd + 5'd1;
  // A ready in the same cycle wins over an expiring count.
  assign wd_expire = active && !alu_valid && !alu_ready && (wd_inc == 5'(TIMEOUT));
  assign phase = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state                <= S_IDLE;
      k                    <= '0;
      m                    <= 8'd0;
      i                    <= 8'd0;
      j                    <= 8'd0;
      wd                   <= 5'd0;
      alu_valid            <= 1'b0;
      alu_state            <= 2'd0;
      alu_keep_flag        <= 1'b0;
      alu_consecutive_flag <= 1'b0;
      busy                 <= 1'b0;
      done                 <= 1'b0;
      err                  <= 1'b0;
    end else begin
      alu_valid <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;

      if (active) wd <= (alu_valid || alu_ready) ? 5'd0 : wd_inc;
      else        wd <= 5'd0;

      case (state)
        S_IDLE: begin
          if (start) begin
            k <= scalar;
            m <= msb;
            if (scalar == '0) begin
              state <= S_FIN;
              done  <= 1'b1;
              err   <= 1'b1;
            end else begin
              state     <= S_PRE;
              busy      <= 1'b1;
              alu_valid <= 1'b1;
              alu_state <= 2'd0;
            end
          end
        end

        S_PRE: begin
          if (alu_ready) begin
            if (m == 8'd0) begin
              // k == 1: no doubling needed, go straight to inversion.
              state                <= S_INV;
              j                    <= 8'd254;
              alu_valid            <= 1'b1;
              alu_state            <= 2'd2;
              alu_keep_flag        <= 1'b1;
              alu_consecutive_flag <= EXP[254];
            end else begin
              state                <= S_DBL;
              i                    <= m - 8'd1;
              alu_valid            <= 1'b1;
              alu_state            <= 2'd1;
              alu_keep_flag        <= (m != 8'd1);
              alu_consecutive_flag <= k[m - 8'd1];
            end
          end else if (wd_expire) begin
            state <= S_FIN;
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
          end
        end

        S_DBL: begin
          if (alu_ready) begin
            if (i != 8'd0) begin
              // Next chain element: flags describe bit i-1.
              i                    <= i - 8'd1;
              alu_keep_flag        <= (i != 8'd1);
              alu_consecutive_flag <= k[i - 8'd1];
            end else begin
              state                <= S_INV;
              j                    <= 8'd254;
              alu_valid            <= 1'b1;
              alu_state            <= 2'd2;
              alu_keep_flag        <= 1'b1;
              alu_consecutive_flag <= EXP[254];
            end
          end else if (wd_expire) begin
            state                <= S_FIN;
            done                 <= 1'b1;
            err                  <= 1'b1;
            busy                 <= 1'b0;
            alu_keep_flag        <= 1'b0;
            alu_consecutive_flag <= 1'b0;
          end
        end

        S_INV: begin
          if (alu_ready) begin
            if (j != 8'd0) begin
              j                    <= j - 8'd1;
              alu_keep_flag        <= (j != 8'd1);
              alu_consecutive_flag <= EXP[j - 8'd1];
            end else begin
              state                <= S_MUL;
              alu_valid            <= 1'b1;
              alu_state            <= 2'd3;
              alu_keep_flag        <= 1'b0;
              alu_consecutive_flag <= 1'b0;
            end
          end else if (wd_expire) begin
            state                <= S_FIN;
            done                 <= 1'b1;
            err                  <= 1'b1;
            busy                 <= 1'b0;
            alu_keep_flag        <= 1'b0;
            alu_consecutive_flag <= 1'b0;
          end
        end

        S_MUL: begin
          if (alu_ready) begin
            state <= S_FIN;
            done  <= 1'b1;
            busy  <= 1'b0;
          end else if (wd_expire) begin
            state <= S_FIN;
            done  <= 1'b1;
            err   <= 1'b1;
            busy  <= 1'b0;
          end
        end

        S_FIN: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/scalar_mul_ctrl.md
# scalar_mul_ctrl

Sequencer for the shared modular ALU: computes one Edwards-curve scalar multiplication as an ordered stream of ALU jobs.
- Job order: PRE-CAL, a left-to-right double-and-add chain over the scalar, a modular-inversion chain (exponent q−2), then DIV-MUL.
- Drives the ALU's `in_valid` / `in_state` / `in_keep_flag` / `in_consecutive_flag` and consumes its `out_ready`.
- Sits between the top-level command interface and the ALU. Register-file/LUT preloading (P, r=1) is done by the top level.

## Interface
- `EXP` — default 255'h7FFF…FFEB (2^255−21 = q−2) — inversion exponent, scanned bit 254 down to 0.
- `TIMEOUT` — default 31 — maximum cycles between `alu_valid` or `alu_ready` and the next `alu_ready`.

Ports:
- `clk` in 1 — single clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `start` in 1 — request; sampled only in IDLE.
- `scalar` in 255 — multiplier k; latched when `start` is accepted.
- `alu_ready` in 1 — ALU `out_ready`: one-cycle pulse at the end of a job or chain element.
- `alu_valid` out 1 — one-cycle pulse starting a job or chain.
- `alu_state` out 2 — job code: 0 PRE-CAL, 1 DOUBLE, 2 DIV-INV, 3 DIV-MUL.
- `alu_keep_flag` out 1 — continue the chain after the current element.
- `alu_consecutive_flag` out 1 — DOUBLE: append ADD; DIV-INV: multiply by Z (else by 1).
- `busy` out 1 — high from the cycle after accept until `done`.
- `done` out 1 — one-cycle completion pulse.
- `err` out 1 — valid with `done`: zero scalar or timeout.
- `phase` out 3 — FSM state, for debug.

## Operation
- States: IDLE, PRE, DBL, INV, MUL, FIN.
- IDLE + `start`:
  - Latch k.
  - Latch m = index of highest set bit of k (single-cycle priority encode).
  - k == 0: go to FIN with `err`=1; no ALU job is issued.
  - Otherwise go to PRE.
- PRE: pulse `alu_valid` with `alu_state`=0 on entry; wait for `alu_ready`. Then:
  - m == 0 → INV.
  - m > 0 → DBL with bit index i = m−1.
- DBL:
  - Pulse `alu_valid` with `alu_state`=1 on entry.
  - `alu_consecutive_flag` = k[i].
  - `alu_keep_flag` = (i != 0).
  - On each `alu_ready`: if i != 0, decrement i; otherwise go to INV with j = 254.
- INV:
  - Pulse `alu_valid` with `alu_state`=2 on entry.
  - `alu_consecutive_flag` = EXP[j].
  - `alu_keep_flag` = (j != 0).
  - On each `alu_ready`: decrement j; at j == 0 go to MUL.
- MUL: pulse `alu_valid` with `alu_state`=3 on entry; `alu_ready` → FIN.
- FIN: `done`=1 for one cycle, then IDLE.
- Flag rules:
  - `alu_keep_flag` and `alu_consecutive_flag` are registered.
  - They are stable from the `alu_valid` cycle through the `alu_ready` of the element they describe.
  - They update on the cycle after `alu_ready`.
  - Both are 0 outside DBL/INV.
- Watchdog:
  - A 5-bit counter clears on `alu_valid` or `alu_ready` and increments otherwise while in PRE/DBL/INV/MUL.
  - On reaching TIMEOUT: go to FIN with `err`=1; no further `alu_valid` is issued.
- Ignored inputs:
  - `start` while not in IDLE is ignored.
  - `alu_ready` in IDLE or FIN is ignored.
- `busy` = (state ∉ {IDLE, FIN}).

## Timing
- Reset values: all outputs 0, `phase`=IDLE, i/j/watchdog counter = 0. Reset mid-operation aborts immediately with no `done`.
- `start` accepted at cycle T0 → first `alu_valid` at T0+1.
- Expected `alu_ready` latency after `alu_valid` at cycle v, for the first element:

| Job | `alu_ready` at |
|---|---|
| PRE | v+8 |
| DOUBLE | v+14 |
| DOUBLE+ADD | v+27 |
| DIV-INV | v+8 |
| DIV-MUL | v+6 |

- Inside a keep-chain the next element starts the cycle after `alu_ready`, with no new `alu_valid`.
- A new job's `alu_valid` is issued the cycle after the previous job's final `alu_ready`.
- `done` is asserted the cycle after the MUL `alu_ready`.
- `err` path: zero scalar gives `done`+`err` at T0+1; timeout gives `done`+`err` the cycle after the count hits TIMEOUT.

## Test plan
- **k=1.** Model ALU latencies.
  - PRE `alu_valid` at T1, `alu_ready` at T9.
  - INV `alu_valid` at T10 with 255 elements: all `alu_consecutive_flag`=1 except j=4, 2; `alu_keep_flag` drops at j=0. Last `alu_ready` at T2050.
  - MUL `alu_valid` at T2051, `alu_ready` at T2057; `done` at T2058 with `err`=0. No DBL issued.
- **k=5.**
  - DBL `alu_valid` at T10.
  - Element i=1: `alu_consecutive_flag`=0, `alu_keep_flag`=1, `alu_ready` at T24.
  - Element i=0: `alu_consecutive_flag`=1, `alu_keep_flag`=0, `alu_ready` at T51.
  - INV `alu_valid` at T52; `done` at T2100.
- **k=0.** `done`=1 and `err`=1 at T1; `alu_valid` never asserts.
- **k=2^254+1.** 254 DBL elements with `alu_consecutive_flag`=0 except the last (=1). Exactly one DBL `alu_valid`; `alu_keep_flag` stays 1 until i=0.
- **Timeout.** Drop `alu_ready` after PRE `alu_valid`. `done`+`err` exactly 32 cycles later; no further `alu_valid`. Then `start` is accepted again.
- **Reset and start-while-busy.**
  - `rst` mid-INV: all outputs 0 the next cycle; no `done`.
  - `start` pulses while busy: ignored, and `scalar` changes have no effect.
